// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: request handshake plus response strobe.
interface data_mem_arbiter_if;
  logic        Valid;
  logic        Ready;
  logic        Write;
  logic [2:0]  funct3;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic        Resp_Valid;
  logic [31:0] Read_Data;
  logic        Error;

  modport master (
    output Valid, Write, funct3, Address, Write_Data,
    input  Ready, Resp_Valid, Read_Data, Error
  );

  modport slave (
    input  Valid, Write, funct3, Address, Write_Data,
    output Ready, Resp_Valid, Read_Data, Error
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and word-access sequencer for the single-port data RAM.
// Loads are lane-extracted and extended here; SB/SH become read-modify-write.
module data_mem_arbiter #(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic                Clk,
  input  logic                Reset_n,
  data_mem_arbiter_if.slave   p0,
  data_mem_arbiter_if.slave   p1,
  output logic [31:0]         Mem_Address,
  output logic [31:0]         Mem_Write_Data,
  output logic                Mem_Write_Enable,
  output logic [2:0]          Mem_funct3,
  input  logic [31:0]         Mem_Read_Data
);

  localparam int unsigned ADDR_LIMIT = MEM_WORDS * 4;

  typedef enum logic [2:0] {
    IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP, ERR_RESP
  } state_t;

  state_t      state_q;
  logic        last_grant_q;
  logic        sel_q;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic        pending;
  logic        grant;
  logic        grant_port;
  logic        g_write;
  logic [2:0]  g_f3;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_err;
  logic [4:0]  lane_sh;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic        resp;
  logic        resp_err;
  logic [31:0] resp_data;

  // The RAM is always accessed as whole words.
  assign Mem_funct3 = 3'b010;

  // Illegal funct3, misalignment or out-of-range address for a request.
  function automatic logic req_error(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    if (wr) bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
    else    bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
    out_of_range = (a >= 32'(ADDR_LIMIT));
    return bad_f3 || misaligned || out_of_range;
  endfunction

  // Round-robin winner selection and request field mux.
  always_comb begin
    pending    = p0.Ready | p1.Ready;
    grant_port = (p0.Valid & p1.Valid) ? ~last_grant_q : p1.Valid;
    grant      = (p0.Valid | p1.Valid) &&
                 (((state_q == IDLE) && !pending) || (state_q == RESP) || (state_q == ERR_RESP));
    g_write    = grant_port ? p1.Write      : p0.Write;
    g_f3       = grant_port ? p1.funct3     : p0.funct3;
    g_addr     = grant_port ? p1.Address    : p0.Address;
    g_wdata    = grant_port ? p1.Write_Data : p0.Write_Data;
    g_err      = req_error(g_write, g_f3, g_addr);
  end

  // Load lane extraction/extension and store lane merge from the current RAM word.
  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    shifted   = Mem_Read_Data >> lane_sh;
    load_data = 32'h0;
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
    lane_mask = (f3_q == 3'b000) ? (32'h0000_00FF << lane_sh) : (32'h0000_FFFF << lane_sh);
    merged    = (Mem_Read_Data & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  // Response strobe contents for the cycle that enters RESP/ERR_RESP.
  always_comb begin
    resp      = 1'b0;
    resp_err  = 1'b0;
    resp_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (pending && err_q) begin
          resp     = 1'b1;
          resp_err = 1'b1;
        end
      end
      ACCESS: begin
        resp      = 1'b1;
        resp_data = wr_q ? 32'h0 : load_data;
      end
      RMW_WRITE: resp = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, grant latching and all registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      sel_q            <= 1'b0;
      wr_q             <= 1'b0;
      f3_q             <= 3'b000;
      addr_q           <= 32'h0;
      wdata_q          <= 32'h0;
      err_q            <= 1'b0;
      p0.Ready         <= 1'b0;
      p1.Ready         <= 1'b0;
      p0.Resp_Valid    <= 1'b0;
      p1.Resp_Valid    <= 1'b0;
      p0.Error         <= 1'b0;
      p1.Error         <= 1'b0;
      p0.Read_Data     <= 32'h0;
      p1.Read_Data     <= 32'h0;
      Mem_Address      <= 32'h0;
      Mem_Write_Data   <= 32'h0;
      Mem_Write_Enable <= 1'b0;
    end else begin
      p0.Ready         <= 1'b0;
      p1.Ready         <= 1'b0;
      Mem_Write_Enable <= 1'b0;
      p0.Resp_Valid    <= resp & ~sel_q;
      p1.Resp_Valid    <= resp & sel_q;
      p0.Error         <= resp & resp_err & ~sel_q;
      p1.Error         <= resp & resp_err & sel_q;
      if (resp && !sel_q) p0.Read_Data <= resp_data;
      if (resp && sel_q)  p1.Read_Data <= resp_data;

      case (state_q)
        IDLE: begin
          if (pending) begin
            if (err_q) begin
              state_q <= ERR_RESP;
            end else begin
              Mem_Address <= {addr_q[31:2], 2'b00};
              if (wr_q && (f3_q != 3'b010)) begin
                state_q <= RMW_READ;
              end else begin
                state_q <= ACCESS;
                if (wr_q) begin
                  Mem_Write_Data   <= wdata_q;
                  Mem_Write_Enable <= 1'b1;
                end
              end
            end
          end
        end
        ACCESS:    state_q <= RESP;
        RMW_READ: begin
          Mem_Write_Data   <= merged;
          Mem_Write_Enable <= 1'b1;
          state_q          <= RMW_WRITE;
        end
        RMW_WRITE: state_q <= RESP;
        RESP:      state_q <= IDLE;
        ERR_RESP:  state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase

      if (grant) begin
        sel_q        <= grant_port;
        last_grant_q <= grant_port;
        wr_q         <= g_write;
        f3_q         <= g_f3;
        addr_q       <= g_addr;
        wdata_q      <= g_wdata;
        err_q        <= g_err;
        if (grant_port) p1.Ready <= 1'b1;
        else            p0.Ready <= 1'b1;
      end
    end
  end

endmodule
